// File: rtl/bru_pkg.sv
// Shared types and constants for the EX-stage branch resolution unit.
// Optional statistics counters are enabled with the BRU_STATS_EN macro.
package bru_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;

  // ID->EX entry. pc/imm are kept width-generic in the top, so this carries
  // the XLEN-wide default shape used for the package-level description.
  typedef struct packed {
    logic            valid;
    logic            is_branch;
    logic            pred;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } ex_entry_t;

  // Control-only part of the entry, independent of the PC width.
  typedef struct packed {
    logic valid;
    logic is_branch;
    logic pred;
  } ex_ctrl_t;

endpackage

// File: rtl/bru_flush_fsm.sv
// Flush sequencer: on start, holds flush high for exactly FLUSH_CYCLES cycles.
// Part of branch_resolve_unit (optional BRU_STATS_EN feature lives in the top).
module bru_flush_fsm
  import bru_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic flush,
  output logic idle
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  bru_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  // State and down-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    idle    = 1'b0;
    unique case (state_q)
      IDLE: begin
        idle = 1'b1;
        if (start) begin
          state_d = FLUSH;
          cnt_d   = CNT_LOAD;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: compares the carried prediction with the ALU
// condition, pulses the predictor update, and redirects/flushes on mispredict.
// Optional macro BRU_STATS_EN builds saturating branch/mispredict counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN         = bru_pkg::XLEN,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            id_valid,
  input  logic            id_is_branch,
  input  logic            id_pred_taken,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic            ex_cond_true,
  output logic            branchex,
  output logic            outcome,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic [CNT_W-1:0] branch_cnt
);

  ex_ctrl_t        ex_ctrl;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;

  logic fsm_idle;
  logic resolve;
  logic act;
  logic mis;

  assign resolve = ex_ctrl.valid & ex_ctrl.is_branch & ~stall & fsm_idle;
  assign act     = ex_cond_true;
  assign mis     = resolve & (act != ex_ctrl.pred);

  // ID->EX pipeline register; wrong-path instructions enter as invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: pc/imm are reset along with the control bits; they are plain
    // flops, not a memory array, so a reset costs nothing and keeps
    // simulation free of X on the redirect datapath.
    if (!rst_n) begin
      ex_ctrl <= '0;
      ex_pc   <= '0;
      ex_imm  <= '0;
    end else if (!stall) begin
      ex_ctrl.valid     <= id_valid & ~flush;
      ex_ctrl.is_branch <= id_is_branch;
      ex_ctrl.pred      <= id_pred_taken;
      ex_pc             <= id_pc;
      ex_imm            <= id_imm;
    end
  end

  // Registered resolution outputs; pulses last one cycle, data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branchex       <= 1'b0;
      outcome        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      branchex       <= resolve;
      redirect_valid <= mis;
      if (resolve) outcome <= act;
      if (mis)     redirect_pc <= act ? (ex_pc + ex_imm) : (ex_pc + XLEN'(PC_STEP));
    end
  end

  bru_flush_fsm #(
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_flush_fsm (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mis),
    .flush (flush),
    .idle  (fsm_idle)
  );

`ifdef BRU_STATS_EN
  // Saturating statistics counters, stepped by the output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (branchex && (branch_cnt != '1))           branch_cnt     <= branch_cnt + 1'b1;
      if (redirect_valid && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_branch_resolve_unit;

  localparam int XLEN   = 32;
  localparam int FC     = 2;
  localparam int CNT_W  = 2;
  localparam int CNTMAX = (1 << CNT_W) - 1;

  logic            clk;
  logic            rst_n;
  logic            stall;
  logic            id_valid;
  logic            id_is_branch;
  logic            id_pred_taken;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  logic            ex_cond_true;
  logic            branchex;
  logic            outcome;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic [CNT_W-1:0] mispredict_cnt;
  logic [CNT_W-1:0] branch_cnt;

  branch_resolve_unit #(
    .XLEN         (XLEN),
    .FLUSH_CYCLES (FC),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .id_valid       (id_valid),
    .id_is_branch   (id_is_branch),
    .id_pred_taken  (id_pred_taken),
    .id_pc          (id_pc),
    .id_imm         (id_imm),
    .ex_cond_true   (ex_cond_true),
    .branchex       (branchex),
    .outcome        (outcome),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .mispredict_cnt (mispredict_cnt),
    .branch_cnt     (branch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what sits in EX, how many flush cycles remain, and the
  // outputs the DUT should show after the most recent edge.
  logic            m_v, m_br, m_pred;
  logic [XLEN-1:0] m_pc, m_imm;
  int              m_rem;
  logic            e_bx, e_out, e_rv, e_fl;
  logic [XLEN-1:0] e_rpc;
  int              e_bc, e_mc;
  int              pulses;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_br = 0; m_pred = 0; m_pc = '0; m_imm = '0; m_rem = 0;
    e_bx = 0; e_out = 0; e_rv = 0; e_fl = 0; e_rpc = '0; e_bc = 0; e_mc = 0;
  endtask

  task automatic check_all();
    check("branchex", 64'(branchex), 64'(e_bx));
    check("outcome", 64'(outcome), 64'(e_out));
    check("redirect_valid", 64'(redirect_valid), 64'(e_rv));
    check("redirect_pc", 64'(redirect_pc), 64'(e_rpc));
    check("flush", 64'(flush), 64'(e_fl));
`ifdef BRU_STATS_EN
    check("branch_cnt", 64'(branch_cnt), 64'(e_bc));
    check("mispredict_cnt", 64'(mispredict_cnt), 64'(e_mc));
`else
    check("branch_cnt_tied", 64'(branch_cnt), 64'd0);
    check("mispredict_cnt_tied", 64'(mispredict_cnt), 64'd0);
`endif
  endtask

  // Drive one cycle of inputs (called at negedge), advance the model across
  // the coming rising edge, then compare on the following falling edge.
  task automatic step(input logic v, input logic br, input logic pred,
                      input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                      input logic cond, input logic st);
    logic resolve, mis, was_flushing;
    id_valid = v; id_is_branch = br; id_pred_taken = pred;
    id_pc = pc; id_imm = imm; ex_cond_true = cond; stall = st;

    resolve      = m_v && m_br && !st && (m_rem == 0);
    mis          = resolve && (cond != m_pred);
    was_flushing = (m_rem > 0);

    if (e_bx && e_bc < CNTMAX) e_bc++;
    if (e_rv && e_mc < CNTMAX) e_mc++;

    e_bx = resolve;
    e_rv = mis;
    if (resolve) e_out = cond;
    if (mis)     e_rpc = cond ? (m_pc + m_imm) : (m_pc + 32'd4);

    if (mis)             m_rem = FC;
    else if (m_rem > 0)  m_rem--;
    e_fl = (m_rem > 0);

    if (!st) begin
      m_v = v && !was_flushing; m_br = br; m_pred = pred; m_pc = pc; m_imm = imm;
    end

    @(posedge clk);
    @(negedge clk);
    if (branchex) pulses++;
    check_all();
  endtask

  task automatic idle_cycle(input logic cond);
    step(1'b0, 1'b0, 1'b0, '0, '0, cond, 1'b0);
  endtask

  initial begin
    model_reset();
    pulses = 0;
    // Reset held with active inputs: everything stays zero.
    rst_n = 1'b0; stall = 1'b0; id_valid = 1'b1; id_is_branch = 1'b1;
    id_pred_taken = 1'b0; id_pc = 32'h100; id_imm = 32'h20; ex_cond_true = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_branchex", 64'(branchex), 64'd0);
    check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_outcome", 64'(outcome), 64'd0);
    rst_n = 1'b1;
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Correct prediction, taken.
    step(1'b1, 1'b1, 1'b1, 32'h100, 32'h20, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    check("corr_branchex", 64'(branchex), 64'd1);
    check("corr_outcome", 64'(outcome), 64'd1);
    check("corr_no_redirect", 64'(redirect_valid), 64'd0);
    check("corr_no_flush", 64'(flush), 64'd0);
    idle_cycle(1'b0);

    // Mispredict taken; a branch in ID during the redirect must never resolve.
    step(1'b1, 1'b1, 1'b0, 32'h100, 32'h20, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h200, 32'h40, 1'b1, 1'b0);
    check("mt_redirect_valid", 64'(redirect_valid), 64'd1);
    check("mt_redirect_pc", 64'(redirect_pc), 64'h120);
    check("mt_flush_1", 64'(flush), 64'd1);
    step(1'b1, 1'b1, 1'b0, 32'h300, 32'h8, 1'b1, 1'b0);
    check("mt_flush_2", 64'(flush), 64'd1);
    check("mt_wrongpath_quiet", 64'(branchex), 64'd0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    check("mt_flush_done", 64'(flush), 64'd0);
    idle_cycle(1'b1);
    check("mt_window_never_resolves", 64'(branchex), 64'd0);

    // Mispredict not-taken with PC wrap-around.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    check("wrap_redirect_pc", 64'(redirect_pc), 64'h0);
    check("wrap_outcome", 64'(outcome), 64'd0);
    repeat (3) idle_cycle(1'b0);

    // Branch held in EX by a 3-cycle stall resolves exactly once.
    pulses = 0;
    step(1'b1, 1'b1, 1'b1, 32'h400, 32'h4, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h500, 32'h4, 1'b1, 1'b1);
    check("stall_no_pulse_yet", 64'(pulses), 64'd0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    check("stall_pulse_after_release", 64'(branchex), 64'd1);
    repeat (2) idle_cycle(1'b0);
    check("stall_single_pulse", 64'(pulses), 64'd1);

    // Asynchronous reset in the middle of a flush.
    step(1'b1, 1'b1, 1'b0, 32'h600, 32'h8, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    check("pre_rst_flush", 64'(flush), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_flush", 64'(flush), 64'd0);
    check("async_rst_redirect_pc", 64'(redirect_pc), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle(1'b0);

    // Five mispredicts: counters saturate at 3 when the feature is built.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(k * 16), 32'h40, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      repeat (FC + 1) idle_cycle(1'b0);
    end
`ifdef BRU_STATS_EN
    check("sat_mispredict_cnt", 64'(mispredict_cnt), 64'd3);
    check("sat_branch_cnt", 64'(branch_cnt), 64'd3);
`endif

    // Randomized traffic.
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic [XLEN-1:0] pc;
      pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 6), 1'($urandom),
           pc, $urandom, 1'($urandom), ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
EX-stage branch resolution block, directly upstream of the branch predictor. It carries each branch's prediction from ID into EX and compares it with the actual condition from the ALU. It then produces the predictor update pulse (branchex/outcome), plus the redirect and flush controls for the fetch/decode stages on a mispredict.

Parameters:
XLEN, 32, width of PC and immediate
FLUSH_CYCLES, 2, cycles flush stays asserted after a mispredict (1..7)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipeline hold; freezes the ID->EX register and suppresses resolution
id_valid  in  1  ID stage holds a real instruction
id_is_branch  in  1  ID instruction is a conditional branch
id_pred_taken  in  1  prediction supplied at fetch for this instruction
id_pc  in  XLEN  PC of ID instruction
id_imm  in  XLEN  sign-extended branch offset
ex_cond_true  in  1  ALU compare result for the instruction currently in EX (combinational)
branchex  out  1  one-cycle pulse: a branch resolved (predictor update enable)
outcome  out  1  actual direction of the resolved branch, valid with branchex
redirect_valid  out  1  one-cycle pulse on a mispredict
redirect_pc  out  XLEN  correct next PC, valid with redirect_valid
flush  out  1  kill IF/ID contents
mispredict_cnt  out  CNT_W  saturating mispredict count (optional feature)
branch_cnt  out  CNT_W  saturating resolved-branch count (optional feature)

Behaviour:
- Reset: all outputs 0. EX entry invalid. FSM in IDLE. Counters 0. Reset is asynchronous and takes effect mid-flush or mid-stall with no residue.
- ID->EX register: fields valid, is_branch, pred, pc, imm.
  - Loads on each clk with !stall.
  - Loads valid=0 when flush is high or the FSM is in FLUSH, so wrong-path instructions are dropped.
  - Holds all fields while stall=1.
- Resolve condition: ex_valid & ex_is_branch & !stall & FSM==IDLE. At most one resolution per EX entry.
- On resolve, act = ex_cond_true and mis = (act != ex_pred).
- Next edge (registered, latency 1 cycle):
  - branchex=1, outcome=act.
  - If mis: redirect_valid=1 and redirect_pc = act ? ex_pc+ex_imm : ex_pc+4. Arithmetic is modulo 2^XLEN; wrap-around is allowed.
- All pulse outputs are 0 in every other cycle. outcome and redirect_pc hold their last value.
- FSM states:
  - IDLE: on resolve & mis, go to FLUSH and load cnt=FLUSH_CYCLES-1.
  - FLUSH: flush=1. Decrement cnt; return to IDLE when cnt==0.
  - Flush is therefore high for exactly FLUSH_CYCLES cycles, starting the same edge as redirect_valid.
- stall during FLUSH: the FSM still counts down. Redirect has priority over stall.
- A correctly predicted branch does not flush and does not redirect.
- A non-branch instruction in EX produces no outputs.

Optional Feature:
BRU_STATS_EN
- Defined:
  - branch_cnt increments on each branchex pulse.
  - mispredict_cnt increments on each redirect_valid pulse.
  - Both saturate at 2^CNT_W-1 and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package bru_pkg:
  - XLEN default
  - FSM state enum {IDLE, FLUSH}
  - struct for the ID->EX entry (valid, is_branch, pred, pc, imm)
  - constant PC_STEP=4
- One natural sub-module, bru_flush_fsm: state register, down counter and flush output. Input is start; the parameter is FLUSH_CYCLES.

Test Plan:
- Reset: hold rst_n=0 with active inputs -> all outputs 0. Release -> no pulses until a branch reaches EX.
- Correct prediction: id_pc=0x100, imm=0x20, pred=1, then ex_cond_true=1 -> branchex=1 and outcome=1 one cycle later; redirect_valid=0; flush=0.
- Mispredict taken: pc=0x100, imm=0x20, pred=0, cond=1 -> redirect_valid=1 with redirect_pc=0x120, flush high exactly 2 cycles. An ID branch arriving in that window never resolves.
- Mispredict not-taken with wrap: pc=0xFFFFFFFC, pred=1, cond=0 -> redirect_pc=0x00000000, outcome=0.
- Stall: branch in EX with stall=1 for 3 cycles, then released -> exactly one branchex pulse, on the edge after stall drops. Asserting rst_n=0 during FLUSH -> flush drops immediately and the FSM returns to IDLE.
- BRU_STATS_EN with CNT_W=2: 5 mispredicts -> mispredict_cnt=3 (saturated) and branch_cnt=3. Without the macro, both ports stay 0.
